// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Takes a byte stream (16-bit big-endian word count, then big-endian 32-bit
// words) and writes each word into imem at BASE+index. Holds the core in
// reset (busy_o) until the image is complete.
//   clk, rst (async, active-low)
//   byte_i/byte_v_i/byte_ready_o : incoming byte stream handshake
//   start_i                      : re-arm pulse, honoured only in DONE
//   mem_a_o/mem_w_o/mem_d_o      : imem write port
//   busy_o/done_o                : load status
module imem_loader #(
  parameter int unsigned     ADDR = 16,
  parameter int unsigned     WORD = 32,
  parameter logic [ADDR-1:0] BASE = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      byte_i,
  input  logic            byte_v_i,
  output logic            byte_ready_o,
  input  logic            start_i,
  output logic [ADDR-1:0] mem_a_o,
  output logic            mem_w_o,
  output logic [WORD-1:0] mem_d_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     count;
  logic [ADDR-1:0] index;
  logic [1:0]      byte_sel;
  logic [WORD-1:0] shift;
  logic [ADDR-1:0] mem_a;
  logic            accept;

  assign accept = byte_v_i && byte_ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LEN_HI;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    byte_ready_o = 1'b0;
    mem_w_o      = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (state)
      LEN_HI: begin
        byte_ready_o = 1'b1;
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        byte_ready_o = 1'b1;
        if (accept) state_nxt = (count[15:8] == 8'd0 && byte_i == 8'd0) ? DONE : DATA;
      end
      DATA: begin
        byte_ready_o = 1'b1;
        if (accept && byte_sel == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        mem_w_o   = 1'b1;
        // count is decremented on leaving WRITE; count==1 means none left
        state_nxt = (count == 16'd1) ? DONE : DATA;
      end
      DONE: begin
        busy_o = 1'b0;
        done_o = 1'b1;
        if (start_i) state_nxt = LEN_HI;
      end
      default: state_nxt = LEN_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      index    <= '0;
      byte_sel <= '0;
      shift    <= '0;
      mem_a    <= BASE;
    end else begin
      case (state)
        LEN_HI: if (accept) count[15:8] <= byte_i;
        LEN_LO: begin
          if (accept) begin
            count[7:0] <= byte_i;
            index      <= '0;
            byte_sel   <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            shift    <= {shift[WORD-9:0], byte_i};
            byte_sel <= byte_sel + 2'd1;
            // address registered ahead so it is valid for the whole WRITE cycle
            if (byte_sel == 2'd3) mem_a <= BASE + index;
          end
        end
        WRITE: begin
          index    <= index + 1'b1;
          count    <= count - 16'd1;
          byte_sel <= '0;
        end
        DONE: if (start_i) index <= '0;
        default: ;
      endcase
    end
  end

  assign mem_a_o = mem_a;
  assign mem_d_o = shift;

endmodule
